// File: rtl/dmem_responder.sv
// Data-side memory responder: accepts one word-addressed read/write at a time,
// answers after WAIT_CYCLES wait states, and holds busy while a request is outstanding.
module dmem_responder #(
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE        = 32'h0000_0000
) (
    input  logic        clka,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  wmask,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_WAIT    = 2'd1;
    localparam logic [1:0]  S_RESP    = 2'd2;
    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [31:0] HI_MASK   = ~((32'd4 << DEPTH_LOG2) - 32'd1);
    localparam logic [2:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    logic [1:0]            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  wr_q, wr_d;
    logic [3:0]            wmask_q, wmask_d;
    logic                  data_ok_q, data_ok_d;
    logic                  err_q, err_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           mem_q [DEPTH];

    logic                  go_resp_s;
    logic [31:0]           src_addr_s;
    logic                  src_wr_s;
    logic                  src_in_range_s;
    logic [DEPTH_LOG2-1:0] src_idx_s;
    logic [DEPTH_LOG2-1:0] wr_idx_s;

    assign addr_ok  = req && (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign data_ok  = data_ok_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign wr_idx_s = addr_q[DEPTH_LOG2+1:2];

    // With zero wait states RESP follows IDLE directly, so the response is built from the live request.
    always_comb begin
        src_addr_s     = (state_q == S_IDLE) ? addr : addr_q;
        src_wr_s       = (state_q == S_IDLE) ? wr : wr_q;
        src_in_range_s = ((src_addr_s & HI_MASK) == (BASE & HI_MASK));
        src_idx_s      = src_addr_s[DEPTH_LOG2+1:2];
    end

    // Next-state, wait counter, request latch and registered response.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        wmask_d   = wmask_q;
        go_resp_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    wr_d    = wr;
                    wmask_d = wmask;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d   = S_RESP;
                        go_resp_s = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d   = S_RESP;
                    go_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (go_resp_s) begin
            data_ok_d = 1'b1;
            err_d     = !src_in_range_s;
            if (!src_wr_s && src_in_range_s) begin
                rdata_d = mem_q[src_idx_s];
            end else begin
                rdata_d = 32'd0;
            end
        end else begin
            data_ok_d = 1'b0;
            err_d     = 1'b0;
            rdata_d   = 32'd0;
        end
    end

    // Control and output registers.
    always_ff @(posedge clka) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            wr_q      <= 1'b0;
            wmask_q   <= 4'd0;
            data_ok_q <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            wmask_q   <= wmask_d;
            data_ok_q <= data_ok_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    // Byte-lane write commits on the RESP edge; err_q marks out-of-range, and reset cancels it.
    always_ff @(posedge clka) begin
        if (!rst && (state_q == S_RESP) && wr_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_q[i]) begin
                    mem_q[wr_idx_s][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: three responders (1, 3 and 0 wait states) driven with directed
// and random transactions, checked against a byte-level reference memory.
module tb_dmem_responder;

    logic        clka = 1'b0;
    logic        rst;
    logic [2:0]  req, wr, addr_ok, data_ok, err, busy;
    logic [3:0]  wmask [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic [31:0] mdl   [int];
    logic [3:0]  kmask [int];

    always #5 clka = ~clka;

    dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(1), .BASE(32'h0000_0000)) u_w1 (
        .clka(clka), .rst(rst), .req(req[0]), .wr(wr[0]), .wmask(wmask[0]), .addr(addr[0]),
        .wdata(wdata[0]), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .rdata(rdata[0]),
        .err(err[0]), .busy(busy[0]));

    dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(3), .BASE(32'h8000_0400)) u_w3 (
        .clka(clka), .rst(rst), .req(req[1]), .wr(wr[1]), .wmask(wmask[1]), .addr(addr[1]),
        .wdata(wdata[1]), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .rdata(rdata[1]),
        .err(err[1]), .busy(busy[1]));

    dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0), .BASE(32'h0000_0000)) u_w0 (
        .clka(clka), .rst(rst), .req(req[2]), .wr(wr[2]), .wmask(wmask[2]), .addr(addr[2]),
        .wdata(wdata[2]), .addr_ok(addr_ok[2]), .data_ok(data_ok[2]), .rdata(rdata[2]),
        .err(err[2]), .busy(busy[2]));

    function automatic int w_of(input int i);
        case (i)
            0: return 1;
            1: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int dl_of(input int i);
        return (i == 1) ? 8 : 10;
    endfunction

    function automatic logic [31:0] base_of(input int i);
        return (i == 1) ? 32'h8000_0400 : 32'h0000_0000;
    endfunction

    function automatic logic in_rng(input int i, input logic [31:0] a);
        if (a < base_of(i)) return 1'b0;
        return ((a - base_of(i)) >> 2) < (32'd1 << dl_of(i));
    endfunction

    function automatic int key_of(input int i, input logic [31:0] a);
        return i * 65536 + int'((a - base_of(i)) >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction on responder i, checked against the reference memory.
    task automatic txn(input int i, input logic w, input logic [3:0] m, input logic [31:0] a,
                       input logic [31:0] d, input string tag);
        int          n;
        int          key;
        logic        exp_err;
        logic        known;
        logic [31:0] exp_rd;
        logic [31:0] tmp;
        exp_err = !in_rng(i, a);
        key     = key_of(i, a);
        known   = 1'b1;
        exp_rd  = 32'd0;
        if (!exp_err && !w) begin
            known = mdl.exists(key) && (kmask[key] == 4'hF);
            if (known) exp_rd = mdl[key];
        end
        @(negedge clka);
        req[i] = 1'b1; wr[i] = w; wmask[i] = m; addr[i] = a; wdata[i] = d;
        #1;
        n = 0;
        while (!addr_ok[i] && n < 20) begin
            @(negedge clka); #1; n++;
        end
        chk({tag, ".accept"}, 32'(addr_ok[i]), 32'd1);
        @(posedge clka); #1;
        req[i] = 1'b0; wr[i] = 1'($urandom); wmask[i] = 4'($urandom);
        addr[i] = $urandom; wdata[i] = $urandom;
        n = 0;
        do begin
            @(negedge clka); #1; n++;
        end while (!data_ok[i] && n < 20);
        chk({tag, ".latency"}, 32'(n), 32'(w_of(i) + 1));
        chk({tag, ".err"}, 32'(err[i]), 32'(exp_err));
        if (known) chk({tag, ".rdata"}, rdata[i], exp_rd);
        @(negedge clka); #1;
        chk({tag, ".pulse"}, {31'd0, data_ok[i]} | {31'd0, busy[i]} | rdata[i], 32'd0);
        if (w && !exp_err) begin
            if (!mdl.exists(key)) begin
                mdl[key] = 32'd0; kmask[key] = 4'd0;
            end
            tmp = mdl[key];
            for (int l = 0; l < 4; l++) begin
                if (m[l]) begin
                    tmp[8*l +: 8] = d[8*l +: 8];
                    kmask[key][l] = 1'b1;
                end
            end
            mdl[key] = tmp;
        end
    endtask

    task automatic rand_txn(input int i);
        logic [31:0] a;
        int          ws;
        if ($urandom_range(0, 5) == 0) begin
            a = base_of(i) + (32'd4 << dl_of(i)) + 32'($urandom_range(0, 63));
        end else begin
            ws = $urandom_range(0, 16);
            if (ws == 16) ws = (1 << dl_of(i)) - 1;
            a = base_of(i) + 32'(ws) * 32'd4 + 32'($urandom_range(0, 3));
        end
        txn(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, "rand");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc[$];
        int busy_n;
        int overlap;
        int seen;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; wr[i] = 1'b0; wmask[i] = 4'd0; addr[i] = 32'd0; wdata[i] = 32'd0;
        end
        repeat (3) @(negedge clka);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset.busy", 32'(busy[i]), 32'd0);
            chk("reset.data_ok", 32'(data_ok[i]), 32'd0);
            chk("reset.err", 32'(err[i]), 32'd0);
            chk("reset.rdata", rdata[i], 32'd0);
        end
        rst = 1'b0;

        // Single-wait-state responder: full write, byte-masked write, range checks.
        txn(0, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, "w1.wr10");
        txn(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0, "w1.rd10");
        txn(0, 1'b1, 4'b0100, 32'h0000_0012, 32'h00AA_0000, "w1.bytewr");
        txn(0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, "w1.rdmask");
        chk("w1.mask_model", mdl[key_of(0, 32'h10)], 32'hDEAA_BEEF);
        txn(0, 1'b1, 4'hF, 32'h0000_0000, 32'h1234_5678, "w1.wr0");
        txn(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0, "w1.oor_rd");
        txn(0, 1'b1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF, "w1.oor_wr");
        txn(0, 1'b0, 4'hF, 32'h0000_0000, 32'h0, "w1.rd0");
        txn(0, 1'b1, 4'hF, 32'h0000_0FFC, 32'hA5A5_0F0F, "w1.wrtop");
        txn(0, 1'b0, 4'hF, 32'h0000_0FFF, 32'h0, "w1.rdtop");

        // Three-wait-state responder with a non-zero base.
        txn(1, 1'b1, 4'hF, 32'h8000_0400, 32'hCAFE_F00D, "w3.wrbase");
        txn(1, 1'b0, 4'hF, 32'h8000_0400, 32'h0, "w3.rdbase");
        txn(1, 1'b0, 4'hF, 32'h8000_03FC, 32'h0, "w3.below");
        txn(1, 1'b0, 4'hF, 32'h8000_0800, 32'h0, "w3.above");

        // Continuous request: accepts only in IDLE, five cycles apart, four busy cycles each.
        @(negedge clka);
        req[1] = 1'b1; wr[1] = 1'b0; wmask[1] = 4'hF; addr[1] = 32'h8000_0400;
        busy_n = 0; overlap = 0;
        for (int c = 0; c < 25; c++) begin
            #1;
            if (addr_ok[1]) acc.push_back(c);
            if (busy[1]) busy_n++;
            if (addr_ok[1] && busy[1]) overlap++;
            @(negedge clka);
        end
        req[1] = 1'b0;
        chk("bp.accepts", 32'(acc.size()), 32'd5);
        for (int k = 1; k < acc.size(); k++) chk("bp.spacing", 32'(acc[k] - acc[k-1]), 32'd5);
        chk("bp.busy_cycles", 32'(busy_n), 32'd20);
        chk("bp.overlap", 32'(overlap), 32'd0);
        seen = 0;
        while (busy[1] && seen < 20) begin
            @(negedge clka); #1; seen++;
        end
        chk("bp.drain", 32'(busy[1]), 32'd0);

        // Reset while the write waits: dropped, no response, old data survives.
        txn(0, 1'b1, 4'hF, 32'h0000_0020, 32'h1111_1111, "rw.pre");
        @(negedge clka);
        req[0] = 1'b1; wr[0] = 1'b1; wmask[0] = 4'hF; addr[0] = 32'h20; wdata[0] = 32'h5555_5555;
        #1 chk("rw.accept", 32'(addr_ok[0]), 32'd1);
        @(posedge clka); #1;
        req[0] = 1'b0; rst = 1'b1;
        @(negedge clka); #1 chk("rw.busy_wait", 32'(busy[0]), 32'd1);
        @(posedge clka); #1 rst = 1'b0;
        @(negedge clka); #1;
        chk("rw.busy_after", 32'(busy[0]), 32'd0);
        chk("rw.no_data_ok", 32'(data_ok[0]), 32'd0);
        seen = 0;
        repeat (4) begin
            @(negedge clka); #1;
            if (data_ok[0]) seen++;
        end
        chk("rw.no_late_resp", 32'(seen), 32'd0);
        txn(0, 1'b0, 4'hF, 32'h0000_0020, 32'h0, "rw.read");

        // Zero-wait-state responder: T+1 response, empty mask, reset in the RESP cycle.
        txn(2, 1'b1, 4'hF, 32'h0000_0040, 32'h0BAD_CAFE, "w0.wr");
        txn(2, 1'b1, 4'h0, 32'h0000_0040, 32'hFFFF_FFFF, "w0.nomask");
        txn(2, 1'b0, 4'hF, 32'h0000_0040, 32'h0, "w0.rd");
        @(negedge clka);
        req[2] = 1'b1; wr[2] = 1'b1; wmask[2] = 4'hF; addr[2] = 32'h40; wdata[2] = 32'h7777_7777;
        #1 chk("rr.accept", 32'(addr_ok[2]), 32'd1);
        @(posedge clka); #1;
        req[2] = 1'b0; rst = 1'b1;
        @(negedge clka); #1 chk("rr.resp_cycle", 32'(data_ok[2]), 32'd1);
        @(posedge clka); #1 rst = 1'b0;
        txn(2, 1'b0, 4'hF, 32'h0000_0040, 32'h0, "rr.read");

        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 3; i++) rand_txn(i);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
